ysyx_25020037_wbu: RTL and testbench

//  Write-back/commit stage, directly downstream of the LSU. Accepts one retired instruction per valid/ready handshake.

---
 rtl/ysyx_25020037_wbu_pkg.sv | 41 ++++
 rtl/ysyx_25020037_csr_file.sv | 93 +++++++++
 rtl/ysyx_25020037_wbu.sv | 127 ++++++++++++
 tb/tb_ysyx_25020037_wbu.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25020037_wbu_pkg.sv
// WBU shared definitions: CSR addresses, trap causes, mstatus fields,
// FSM states and the retiring-entry bundle.
package ysyx_25020037_wbu_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MINSTRH  = 12'hB82;

  localparam logic [31:0] MCAUSE_LD_FAULT = 32'd5;
  localparam logic [31:0] MCAUSE_ST_FAULT = 32'd7;
  localparam logic [31:0] MCAUSE_ECALL    = 32'd11;

  localparam int MS_MIE    = 3;
  localparam int MS_MPIE   = 7;
  localparam int MS_MPP_LO = 11;
  localparam int MS_MPP_HI = 12;

  typedef enum logic {
    S_IDLE,
    S_COMMIT
  } wbu_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [3:0]  rd;
    logic        gpr_we;
    logic [31:0] gpr_wdata;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        ecall;
    logic        mret;
    logic        is_read;
    logic        fault;
  } wbu_entry_t;

endpackage

// File: rtl/ysyx_25020037_csr_file.sv
// Machine CSRs with trap/mret side effects and a combinational read port.
// YSYX_25020037_MINSTRET_EN adds a 64-bit retired-instruction counter.
module ysyx_25020037_csr_file
  import ysyx_25020037_wbu_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST   = 32'h0000_0000,
  parameter logic [31:0] MSTATUS_RST = 32'h0000_1800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_commit,
  input  logic [31:0] i_pc,
  input  logic        i_csr_we,
  input  logic [11:0] i_csr_addr,
  input  logic [31:0] i_csr_wdata,
  input  logic        i_ecall,
  input  logic        i_mret,
  input  logic        i_is_read,
  input  logic        i_fault,
  input  logic [11:0] i_raddr,
  output logic [31:0] o_rdata,
  output logic [31:0] o_mtvec,
  output logic [31:0] o_mepc
);

  logic [31:0] r_mstatus;
  logic [31:0] r_mtvec;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic        w_trap;

  assign w_trap  = i_fault | i_ecall;
  assign o_mtvec = r_mtvec;
  assign o_mepc  = r_mepc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mstatus <= MSTATUS_RST;
      r_mtvec   <= MTVEC_RST;
      r_mepc    <= 32'h0;
      r_mcause  <= 32'h0;
    end else if (i_commit) begin
      if (w_trap) begin
        r_mepc   <= i_pc;
        r_mcause <= i_fault ? (i_is_read ? MCAUSE_LD_FAULT
                                         : MCAUSE_ST_FAULT)
                            : MCAUSE_ECALL;
        r_mstatus[MS_MPIE] <= r_mstatus[MS_MIE];
        r_mstatus[MS_MIE]  <= 1'b0;
        r_mstatus[MS_MPP_HI:MS_MPP_LO] <= 2'b11;
      end else if (i_mret) begin
        r_mstatus[MS_MIE]  <= r_mstatus[MS_MPIE];
        r_mstatus[MS_MPIE] <= 1'b1;
      end else if (i_csr_we) begin
        case (i_csr_addr)
          CSR_MSTATUS: r_mstatus <= i_csr_wdata;
          CSR_MTVEC:   r_mtvec   <= {i_csr_wdata[31:2], 2'b00};
          CSR_MEPC:    r_mepc    <= {i_csr_wdata[31:2], 2'b00};
          CSR_MCAUSE:  r_mcause  <= i_csr_wdata;
          default: ;
        endcase
      end
    end
  end

`ifdef YSYX_25020037_MINSTRET_EN
  logic [63:0] r_minstret;

  // Counts every commit pulse, traps included; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)
      r_minstret <= 64'h0;
    else if (i_commit)
      r_minstret <= r_minstret + 64'h1;
  end
`endif

  always_comb begin
    o_rdata = 32'h0;
    case (i_raddr)
      CSR_MSTATUS:  o_rdata = r_mstatus;
      CSR_MTVEC:    o_rdata = r_mtvec;
      CSR_MEPC:     o_rdata = r_mepc;
      CSR_MCAUSE:   o_rdata = r_mcause;
`ifdef YSYX_25020037_MINSTRET_EN
      CSR_MINSTRET: o_rdata = r_minstret[31:0];
      CSR_MINSTRH:  o_rdata = r_minstret[63:32];
`endif
      default:      o_rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/ysyx_25020037_wbu.sv
// Write-back/commit stage: holding register, IDLE/COMMIT FSM, GPR and dnpc.
// Optional YSYX_25020037_MINSTRET_EN enables minstret in the CSR file.
module ysyx_25020037_wbu
  import ysyx_25020037_wbu_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST   = 32'h0000_0000,
  parameter logic [31:0] MSTATUS_RST = 32'h0000_1800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_valid,
  output logic        wbu_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_next_pc,
  input  logic [3:0]  in_rd,
  input  logic        in_gpr_we,
  input  logic [31:0] in_gpr_wdata,
  input  logic        in_csr_we,
  input  logic [11:0] in_csr_addr,
  input  logic [31:0] in_csr_wdata,
  input  logic        in_ecall,
  input  logic        in_mret,
  input  logic        in_is_read,
  input  logic        in_fault,
  input  logic [11:0] csr_raddr,
  output logic [31:0] csr_rdata,
  output logic        gpr_wen,
  output logic [3:0]  gpr_waddr,
  output logic [31:0] gpr_wdata,
  output logic        wbu_valid,
  output logic [31:0] wbu_dnpc
);

  wbu_state_e  r_state;
  wbu_state_e  w_state_nxt;
  wbu_entry_t  r_hold;
  logic        w_fire;
  logic        w_commit;
  logic [31:0] w_mtvec;
  logic [31:0] w_mepc;
  logic [31:0] w_dnpc;
  logic        r_wen;
  logic [3:0]  r_waddr;
  logic [31:0] r_wdata;
  logic        r_valid;
  logic [31:0] r_dnpc;

  assign wbu_ready = (r_state == S_IDLE);
  assign w_fire    = lsu_valid & wbu_ready;
  assign w_commit  = (r_state == S_COMMIT);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (w_fire) w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_hold <= '0;
    else if (w_fire)
      r_hold <= '{pc: in_pc, next_pc: in_next_pc, rd: in_rd,
                  gpr_we: in_gpr_we, gpr_wdata: in_gpr_wdata,
                  csr_we: in_csr_we, csr_addr: in_csr_addr,
                  csr_wdata: in_csr_wdata, ecall: in_ecall,
                  mret: in_mret, is_read: in_is_read,
                  fault: in_fault};
  end

  // mret returns to mepc as it stood before this commit's update.
  always_comb begin
    w_dnpc = r_hold.next_pc;
    if (r_hold.fault | r_hold.ecall) w_dnpc = w_mtvec;
    else if (r_hold.mret)            w_dnpc = w_mepc;
  end

  always_ff @(posedge clk) begin
    if (rst || !w_commit) begin
      r_wen   <= 1'b0;
      r_waddr <= 4'h0;
      r_wdata <= 32'h0;
      r_valid <= 1'b0;
      r_dnpc  <= 32'h0;
    end else begin
      r_wen   <= r_hold.gpr_we & (r_hold.rd != 4'h0) & ~r_hold.fault;
      r_waddr <= r_hold.rd;
      r_wdata <= r_hold.gpr_wdata;
      r_valid <= 1'b1;
      r_dnpc  <= w_dnpc;
    end
  end

  assign gpr_wen   = r_wen;
  assign gpr_waddr = r_waddr;
  assign gpr_wdata = r_wdata;
  assign wbu_valid = r_valid;
  assign wbu_dnpc  = r_dnpc;

  ysyx_25020037_csr_file #(
    .MTVEC_RST   (MTVEC_RST),
    .MSTATUS_RST (MSTATUS_RST)
  ) u_csr (
    .clk         (clk),
    .rst         (rst),
    .i_commit    (w_commit),
    .i_pc        (r_hold.pc),
    .i_csr_we    (r_hold.csr_we),
    .i_csr_addr  (r_hold.csr_addr),
    .i_csr_wdata (r_hold.csr_wdata),
    .i_ecall     (r_hold.ecall),
    .i_mret      (r_hold.mret),
    .i_is_read   (r_hold.is_read),
    .i_fault     (r_hold.fault),
    .i_raddr     (csr_raddr),
    .o_rdata     (csr_rdata),
    .o_mtvec     (w_mtvec),
    .o_mepc      (w_mepc)
  );

endmodule

// File: tb/tb_ysyx_25020037_wbu.sv
// Bench for ysyx_25020037_wbu: directed table, random vs model, corners.
// Honours YSYX_25020037_MINSTRET_EN for the minstret expectations.
module tb_ysyx_25020037_wbu;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid;
  logic        wbu_ready;
  logic [31:0] in_pc, in_next_pc, in_gpr_wdata, in_csr_wdata;
  logic [3:0]  in_rd;
  logic        in_gpr_we, in_csr_we, in_ecall, in_mret;
  logic        in_is_read, in_fault;
  logic [11:0] in_csr_addr, csr_raddr;
  logic [31:0] csr_rdata;
  logic        gpr_wen;
  logic [3:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        wbu_valid;
  logic [31:0] wbu_dnpc;

  always #5 clk = ~clk;

  ysyx_25020037_wbu dut (
    .clk(clk), .rst(rst), .lsu_valid(lsu_valid), .wbu_ready(wbu_ready),
    .in_pc(in_pc), .in_next_pc(in_next_pc), .in_rd(in_rd),
    .in_gpr_we(in_gpr_we), .in_gpr_wdata(in_gpr_wdata),
    .in_csr_we(in_csr_we), .in_csr_addr(in_csr_addr),
    .in_csr_wdata(in_csr_wdata), .in_ecall(in_ecall), .in_mret(in_mret),
    .in_is_read(in_is_read), .in_fault(in_fault),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .wbu_valid(wbu_valid), .wbu_dnpc(wbu_dnpc)
  );

  typedef struct {
    logic [31:0] pc, npc;
    logic [3:0]  rd;
    logic        gwe;
    logic [31:0] gwd;
    logic        cwe;
    logic [11:0] caddr;
    logic [31:0] cwd;
    logic        ecall, mret, isrd, flt;
  } txn_t;

  typedef struct {
    txn_t        t;
    logic        e_wen;
    logic [31:0] e_dnpc, e_mtvec, e_ms, e_mepc, e_mcause;
  } vec_t;

  int n_pass = 0;
  int n_tot  = 0;

  logic [31:0] m_mtvec, m_ms, m_mepc, m_mcause;
  int unsigned m_cnt;

  task automatic chk32(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  function automatic txn_t tx(input logic [31:0] pc, input logic [31:0] npc,
                              input logic [3:0] rd, input logic gwe,
                              input logic [31:0] gwd, input logic cwe,
                              input logic [11:0] caddr,
                              input logic [31:0] cwd, input logic ecall,
                              input logic mret, input logic isrd,
                              input logic flt);
    txn_t t;
    t.pc = pc; t.npc = npc; t.rd = rd; t.gwe = gwe; t.gwd = gwd;
    t.cwe = cwe; t.caddr = caddr; t.cwd = cwd;
    t.ecall = ecall; t.mret = mret; t.isrd = isrd; t.flt = flt;
    return t;
  endfunction

  task automatic model_reset();
    m_mtvec = 32'h0; m_ms = 32'h1800; m_mepc = 32'h0; m_mcause = 32'h0;
    m_cnt = 0;
  endtask

  // Architectural effect of retiring one instruction.
  task automatic model_apply(input txn_t t, output logic ewen,
                             output logic [31:0] ednpc);
    logic mie, mpie;
    mie  = m_ms[3];
    mpie = m_ms[7];
    ewen = t.gwe && (t.rd != 0) && !t.flt;
    if (t.flt || t.ecall) begin
      ednpc    = m_mtvec;
      m_mepc   = t.pc;
      m_mcause = t.flt ? (t.isrd ? 32'd5 : 32'd7) : 32'd11;
      m_ms[7]  = mie;
      m_ms[3]  = 1'b0;
      m_ms[12:11] = 2'b11;
    end else if (t.mret) begin
      ednpc   = m_mepc;
      m_ms[3] = mpie;
      m_ms[7] = 1'b1;
    end else begin
      ednpc = t.npc;
      if (t.cwe) begin
        if (t.caddr == 12'h300) m_ms = t.cwd;
        if (t.caddr == 12'h305) m_mtvec = t.cwd & ~32'h3;
        if (t.caddr == 12'h341) m_mepc = t.cwd & ~32'h3;
        if (t.caddr == 12'h342) m_mcause = t.cwd;
      end
    end
    m_cnt++;
  endtask

  function automatic logic [31:0] exp_instret();
`ifdef YSYX_25020037_MINSTRET_EN
    return m_cnt;
`else
    return 32'h0;
`endif
  endfunction

  task automatic drive(input txn_t t);
    in_pc = t.pc; in_next_pc = t.npc; in_rd = t.rd;
    in_gpr_we = t.gwe; in_gpr_wdata = t.gwd;
    in_csr_we = t.cwe; in_csr_addr = t.caddr; in_csr_wdata = t.cwd;
    in_ecall = t.ecall; in_mret = t.mret;
    in_is_read = t.isrd; in_fault = t.flt;
  endtask

  task automatic run_txn(input txn_t t, output logic o_wen,
                         output logic [3:0] o_wa, output logic [31:0] o_wd,
                         output logic [31:0] o_dnpc, output logic o_vld);
    int k;
    @(negedge clk);
    drive(t);
    lsu_valid = 1'b1;
    k = 0;
    while (!wbu_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk1("ready_idle", wbu_ready, 1'b1);
    @(posedge clk); #1;
    lsu_valid = 1'b0;
    chk1("ready_busy", wbu_ready, 1'b0);
    chk1("valid_early", wbu_valid, 1'b0);
    @(posedge clk); #1;
    o_wen = gpr_wen; o_wa = gpr_waddr; o_wd = gpr_wdata;
    o_dnpc = wbu_dnpc; o_vld = wbu_valid;
    chk1("ready_back", wbu_ready, 1'b1);
    @(posedge clk); #1;
    chk1("valid_drop", wbu_valid, 1'b0);
    chk1("wen_drop", gpr_wen, 1'b0);
    chk32("waddr_drop", {28'h0, gpr_waddr}, 32'h0);
    chk32("wdata_drop", gpr_wdata, 32'h0);
    chk32("dnpc_drop", wbu_dnpc, 32'h0);
  endtask

  task automatic rd_csr(input logic [11:0] a, output logic [31:0] v);
    csr_raddr = a;
    #1;
    v = csr_rdata;
  endtask

  task automatic check_csrs(input string tag, input logic [31:0] mt,
                            input logic [31:0] ms, input logic [31:0] me,
                            input logic [31:0] mc);
    logic [31:0] v;
    rd_csr(12'h305, v); chk32({tag, "_mtvec"}, v, mt);
    rd_csr(12'h300, v); chk32({tag, "_mstatus"}, v, ms);
    rd_csr(12'h341, v); chk32({tag, "_mepc"}, v, me);
    rd_csr(12'h342, v); chk32({tag, "_mcause"}, v, mc);
  endtask

  task automatic check_commit(input string tag, input txn_t t,
                              input logic ewen, input logic [31:0] ednpc);
    logic wen, vld;
    logic [3:0] wa;
    logic [31:0] wd, dn;
    run_txn(t, wen, wa, wd, dn, vld);
    chk1({tag, "_valid"}, vld, 1'b1);
    chk1({tag, "_wen"}, wen, ewen);
    chk32({tag, "_dnpc"}, dn, ednpc);
    if (ewen) begin
      chk32({tag, "_waddr"}, {28'h0, wa}, {28'h0, t.rd});
      chk32({tag, "_wdata"}, wd, t.gwd);
    end
  endtask

  vec_t tbl[11];

  initial begin
    logic ew;
    logic [31:0] ed, v, cnt0;
    txn_t t;

    tbl[0]  = '{tx(32'h80000000, 32'h80000004, 4'd5, 1, 32'h1234, 0, 12'h0, 0, 0, 0, 0, 0),
                1, 32'h80000004, 32'h0, 32'h1800, 32'h0, 32'h0};
    tbl[1]  = '{tx(32'h80000004, 32'h80000008, 4'd0, 1, 32'hdead, 0, 12'h0, 0, 0, 0, 0, 0),
                0, 32'h80000008, 32'h0, 32'h1800, 32'h0, 32'h0};
    tbl[2]  = '{tx(32'h80000008, 32'h8000000c, 4'd0, 0, 0, 1, 12'h305, 32'h80000103, 0, 0, 0, 0),
                0, 32'h8000000c, 32'h80000100, 32'h1800, 32'h0, 32'h0};
    tbl[3]  = '{tx(32'h8000000c, 32'h80000010, 4'd0, 0, 0, 1, 12'h300, 32'h1888, 0, 0, 0, 0),
                0, 32'h80000010, 32'h80000100, 32'h1888, 32'h0, 32'h0};
    tbl[4]  = '{tx(32'h80000010, 32'h80000014, 4'd0, 0, 0, 1, 12'h342, 32'h55, 1, 0, 0, 0),
                0, 32'h80000100, 32'h80000100, 32'h1880, 32'h80000010, 32'd11};
    tbl[5]  = '{tx(32'h80000100, 32'h80000104, 4'd0, 0, 0, 0, 12'h0, 0, 0, 1, 0, 0),
                0, 32'h80000010, 32'h80000100, 32'h1888, 32'h80000010, 32'd11};
    tbl[6]  = '{tx(32'h80000020, 32'h80000024, 4'd3, 1, 32'h77, 0, 12'h0, 0, 0, 0, 1, 1),
                0, 32'h80000100, 32'h80000100, 32'h1880, 32'h80000020, 32'd5};
    tbl[7]  = '{tx(32'h80000024, 32'h80000028, 4'd0, 0, 0, 0, 12'h0, 0, 0, 0, 0, 1),
                0, 32'h80000100, 32'h80000100, 32'h1800, 32'h80000024, 32'd7};
    tbl[8]  = '{tx(32'h80000028, 32'h8000002c, 4'd9, 1, 32'hcafe, 1, 12'h341, 32'h80000037, 0, 0, 0, 0),
                1, 32'h8000002c, 32'h80000100, 32'h1800, 32'h80000034, 32'd7};
    tbl[9]  = '{tx(32'h8000002c, 32'h80000030, 4'd0, 0, 0, 1, 12'h7c0, 32'h1, 0, 0, 0, 0),
                0, 32'h80000030, 32'h80000100, 32'h1800, 32'h80000034, 32'd7};
    tbl[10] = '{tx(32'h80000040, 32'h80000044, 4'd7, 1, 32'h99, 0, 12'h0, 0, 1, 0, 1, 1),
                0, 32'h80000100, 32'h80000100, 32'h1800, 32'h80000040, 32'd5};

    rst = 1'b1; lsu_valid = 1'b0; csr_raddr = 12'h0;
    drive(tx(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk1("rst_ready", wbu_ready, 1'b1);
    chk1("rst_valid", wbu_valid, 1'b0);
    chk1("rst_wen", gpr_wen, 1'b0);
    chk32("rst_waddr", {28'h0, gpr_waddr}, 32'h0);
    chk32("rst_wdata", gpr_wdata, 32'h0);
    chk32("rst_dnpc", wbu_dnpc, 32'h0);
    check_csrs("rst", 32'h0, 32'h1800, 32'h0, 32'h0);

    for (int i = 0; i < 11; i++) begin
      model_apply(tbl[i].t, ew, ed);
      check_commit($sformatf("tbl%0d", i), tbl[i].t, tbl[i].e_wen,
                   tbl[i].e_dnpc);
      check_csrs($sformatf("tbl%0d", i), tbl[i].e_mtvec, tbl[i].e_ms,
                 tbl[i].e_mepc, tbl[i].e_mcause);
    end
    rd_csr(12'h7c0, v); chk32("unmapped_rd", v, 32'h0);
    rd_csr(12'hb02, v); chk32("instret_lo_tbl", v, exp_instret());
    rd_csr(12'hb82, v); chk32("instret_hi_tbl", v, 32'h0);

    for (int i = 0; i < 40; i++) begin
      int unsigned r, a;
      logic [11:0] addrs [6];
      addrs = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hb02, 12'h7c0};
      r = $urandom_range(0, 7);
      a = $urandom_range(0, 5);
      t = tx({$urandom} & ~32'h3, {$urandom} & ~32'h3,
             4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom,
             1'($urandom_range(0, 1)), addrs[a], $urandom,
             r == 1, r == 2, 1'($urandom_range(0, 1)), r == 0);
      model_apply(t, ew, ed);
      check_commit($sformatf("rnd%0d", i), t, ew, ed);
      check_csrs($sformatf("rnd%0d", i), m_mtvec, m_ms, m_mepc, m_mcause);
    end
    rd_csr(12'hb02, v); chk32("instret_lo_rnd", v, exp_instret());

    rd_csr(12'hb02, cnt0);
    t = tx(32'h80000200, 32'h80000204, 4'd1, 1, 32'h42, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(t);
    lsu_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk1($sformatf("b2b_ready%0d", c), wbu_ready, (c % 2) == 1);
      chk1($sformatf("b2b_valid%0d", c), wbu_valid, (c % 2) == 1);
      if ((c % 2) == 1) begin
        model_apply(t, ew, ed);
        chk32($sformatf("b2b_dnpc%0d", c), wbu_dnpc, ed);
      end
    end
    lsu_valid = 1'b0;
    @(posedge clk); #1;
    chk1("b2b_idle", wbu_valid, 1'b0);
    rd_csr(12'hb02, v);
`ifdef YSYX_25020037_MINSTRET_EN
    chk32("b2b_instret_delta", v - cnt0, 32'd3);
`else
    chk32("b2b_instret_off", v, 32'h0);
`endif

    t = tx(32'h80000300, 32'h80000304, 0, 0, 0, 1, 12'h305, 32'h80000abc,
           0, 0, 0, 0);
    model_apply(t, ew, ed);
    check_commit("pre_rst", t, ew, ed);
    @(negedge clk);
    drive(tx(32'h80000400, 32'h80000404, 4'd2, 1, 32'h5, 0, 0, 0,
             1, 0, 0, 0));
    lsu_valid = 1'b1;
    @(posedge clk); #1;
    lsu_valid = 1'b0;
    chk1("rstc_busy", wbu_ready, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk1("rstc_valid", wbu_valid, 1'b0);
    chk1("rstc_wen", gpr_wen, 1'b0);
    chk1("rstc_ready", wbu_ready, 1'b1);
    rst = 1'b0;
    model_reset();
    check_csrs("rstc", m_mtvec, m_ms, m_mepc, m_mcause);
    rd_csr(12'hb02, v); chk32("rstc_instret", v, 32'h0);
    @(posedge clk); #1;
    chk1("rstc_nopulse", wbu_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
